stopwatch_ctrl: RTL

Button-driven sequencer for the stopwatch counter chain (min0/sec1/sec0/milSec0 digits). Synchronises and edge-detects two raw push-buttons, runs an IDLE/RUN/PAUSED/LAP state machine, and emits the one-cycle `start_resume`, `stop` and `sw_reset` commands that drive the counter chain. It also owns the display path: live digits, or frozen lap digits while a lap is shown, plus a saturating lap counter.

---
 rtl/stopwatch_pkg.sv | 26 ++
 rtl/btn_sync_edge.sv | 44 ++++
 rtl/stopwatch_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch button sequencer.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned LAP_MAX = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_LAP    = 2'd3
  } state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] min0;
    logic [DIGIT_W-1:0] sec1;
    logic [DIGIT_W-1:0] sec0;
    logic [DIGIT_W-1:0] mil0;
  } digits_t;

  // Lap counter increment that sticks at LAP_MAX.
  function automatic logic [DIGIT_W-1:0] lap_inc(input logic [DIGIT_W-1:0] v);
    return (v >= DIGIT_W'(LAP_MAX)) ? DIGIT_W'(LAP_MAX) : v + DIGIT_W'(1);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Raw button synchroniser with rising-edge detect and post-press lockout.
module btn_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCKOUT     = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic accept_en,
  output logic press
);

  localparam int unsigned LO_W = $clog2(LOCKOUT + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [LO_W-1:0]        lock_q, lock_d;

  // press is combinational so the FSM registers the command on the same edge.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
    prev_d = sync_q[SYNC_STAGES-1];
    press  = sync_q[SYNC_STAGES-1] & ~prev_q & (lock_q == '0) & accept_en;
    lock_d = lock_q;
    if (press) begin
      lock_d = LO_W'(LOCKOUT);
    end else if (lock_q != '0) begin
      lock_d = lock_q - LO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      lock_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      lock_q <= lock_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button FSM, command pulses, lap capture and display path.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCKOUT     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_ss,
  input  logic               btn_lr,
  input  logic [DIGIT_W-1:0] min0,
  input  logic [DIGIT_W-1:0] sec1,
  input  logic [DIGIT_W-1:0] sec0,
  input  logic [DIGIT_W-1:0] milSec0,
  output logic               start_resume,
  output logic               stop,
  output logic               sw_reset,
  output logic [DIGIT_W-1:0] disp_min0,
  output logic [DIGIT_W-1:0] disp_sec1,
  output logic [DIGIT_W-1:0] disp_sec0,
  output logic [DIGIT_W-1:0] disp_mil0,
  output logic               running,
  output logic               lap_active,
  output logic [DIGIT_W-1:0] lap_cnt
);

  logic ss_press, lr_press;
  digits_t live;

  state_e             state_q, state_d;
  digits_t            lap_q, lap_d;
  digits_t            disp_q, disp_d;
  logic [DIGIT_W-1:0] cnt_q, cnt_d;
  logic               start_q, start_d;
  logic               stop_q, stop_d;
  logic               clr_q, clr_d;
  logic               running_q, running_d;
  logic               lap_act_q, lap_act_d;

  assign live = '{min0: min0, sec1: sec1, sec0: sec0, mil0: milSec0};

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .LOCKOUT(LOCKOUT)) u_ss (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_ss),
    .accept_en (1'b1),
    .press     (ss_press)
  );

  // Start/stop beats lap/reset; a discarded lr edge does not arm its lockout.
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .LOCKOUT(LOCKOUT)) u_lr (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_lr),
    .accept_en (~ss_press),
    .press     (lr_press)
  );

  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    clr_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ss_press) begin
          state_d = ST_RUN;
          start_d = 1'b1;
        end
      end
      ST_RUN, ST_LAP: begin
        if (ss_press) begin
          state_d = ST_PAUSED;
          stop_d  = 1'b1;
        end else if (lr_press) begin
          state_d = ST_LAP;
          lap_d   = live;
          cnt_d   = lap_inc(cnt_q);
        end
      end
      ST_PAUSED: begin
        if (ss_press) begin
          state_d = ST_RUN;
          start_d = 1'b1;
        end else if (lr_press) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
          cnt_d   = '0;
          lap_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Display follows the next state so LAP entry shows the captured value directly.
    disp_d    = (state_d == ST_LAP) ? lap_d : live;
    running_d = (state_d == ST_RUN) || (state_d == ST_LAP);
    lap_act_d = (state_d == ST_LAP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      lap_q     <= '0;
      disp_q    <= '0;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      clr_q     <= 1'b0;
      running_q <= 1'b0;
      lap_act_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lap_q     <= lap_d;
      disp_q    <= disp_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      clr_q     <= clr_d;
      running_q <= running_d;
      lap_act_q <= lap_act_d;
    end
  end

  assign start_resume = start_q;
  assign stop         = stop_q;
  assign sw_reset     = clr_q;
  assign disp_min0    = disp_q.min0;
  assign disp_sec1    = disp_q.sec1;
  assign disp_sec0    = disp_q.sec0;
  assign disp_mil0    = disp_q.mil0;
  assign running      = running_q;
  assign lap_active   = lap_act_q;
  assign lap_cnt      = cnt_q;

endmodule
